// File: rtl/mux_arb_pkg.sv
// Shared types for the two-requester packet arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK1 = 2'd1,
        ARB_LOCK2 = 2'd2
    } arb_state_t;

    localparam logic SRC_IN1 = 1'b0;
    localparam logic SRC_IN2 = 1'b1;

endpackage

// File: rtl/Mux2.sv
// Plain WIDTH-bit 2:1 multiplexer: sel=0 picks in1, sel=1 picks in2.
module Mux2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in2 : in1;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one Mux2 between two
// valid/ready streams, followed by a single registered output stage.
module mux2_stream_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    input  logic             in2_valid,
    output logic             in2_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    output logic             busy
);

    arb_state_t       state_q;
    logic             prio_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_src_q, out_src_d;

    logic             load;
    logic             grant1, grant2;
    logic             accept;
    logic [WIDTH:0]   mux_out;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    // Output stage can take a beat when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

    // Grant: free arbitration in IDLE, otherwise the locked requester only.
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (in1_valid && in2_valid) begin
                    grant2 = (prio_q == SRC_IN2);
                    grant1 = (prio_q == SRC_IN1);
                end else begin
                    grant1 = in1_valid;
                    grant2 = in2_valid;
                end
            end
            ARB_LOCK1: grant1 = 1'b1;
            ARB_LOCK2: grant2 = 1'b1;
            default: begin
                grant1 = 1'b0;
                grant2 = 1'b0;
            end
        endcase
    end

    assign in1_ready = grant1 && load;
    assign in2_ready = grant2 && load;
    assign accept    = load && ((grant1 && in1_valid) || (grant2 && in2_valid));

    Mux2 #(.WIDTH(WIDTH + 1)) u_mux (
        .in1 ({in1_last, in1_data}),
        .in2 ({in2_last, in2_data}),
        .sel (grant2),
        .out (mux_out)
    );

    assign sel_last = mux_out[WIDTH];
    assign sel_data = mux_out[WIDTH-1:0];

    // Packet lock and round-robin pointer; prio only moves when a packet ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            prio_q  <= SRC_IN1;
        end else if (accept) begin
            if (sel_last) begin
                state_q <= ARB_IDLE;
                prio_q  <= grant2 ? SRC_IN1 : SRC_IN2;
            end else begin
                state_q <= grant2 ? ARB_LOCK2 : ARB_LOCK1;
            end
        end
    end

    // Next output beat: refill on accept, empty on drain, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = accept;
        end
        if (accept) begin
            out_data_d = sel_data;
            out_last_d = sel_last;
            out_src_d  = grant2 ? SRC_IN2 : SRC_IN1;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= SRC_IN1;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != ARB_IDLE) || out_valid_q;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Self-checking bench for mux2_stream_arbiter: directed scenarios plus a
// randomized run against a packet-level reference model and per-source scoreboard.
module tb_mux2_stream_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in1_valid, in1_ready, in1_last;
    logic [W-1:0] in1_data;
    logic         in2_valid, in2_ready, in2_last;
    logic [W-1:0] in2_data;
    logic         out_valid, out_ready, out_last, out_src, busy;
    logic [W-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    mux2_stream_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .in2_data  (in2_data),
        .in2_last  (in2_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Apply reset for two edges; returns 1ns after an edge with rst released.
    task automatic do_reset();
        rst = 1'b1;
        in1_valid = 0; in1_data = '0; in1_last = 0;
        in2_valid = 0; in2_data = '0; in2_last = 0;
        out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || out_src !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b d=%h l=%b s=%b, want 0 0 0 0", out_valid, out_data, out_last, out_src);
        end
        n_checks++;
        if (in1_ready !== 1'b0 || in2_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got r1=%b r2=%b busy=%b, want 0 0 0", in1_ready, in2_ready, busy);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        in1_valid = 1; in1_data = 32'hA5; in1_last = 1; out_ready = 1;
        #1;
        n_checks++;
        if (in1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 1", in1_ready);
        end
        @(posedge clk); #1;
        in1_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5 || out_last !== 1'b1 || out_src !== 1'b0) begin
            n_fail++;
            $display("FAIL single_out: got v=%b d=%h l=%b s=%b, want 1 a5 1 0", out_valid, out_data, out_last, out_src);
        end
    endtask

    task automatic test_alternate();
        int k1, k2, exp;
        do_reset();
        k1 = 0; k2 = 0;
        in1_valid = 1; in1_data = 32'h10; in1_last = 1;
        in2_valid = 1; in2_data = 32'h20; in2_last = 1;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            exp = i % 2;
            #1;
            n_checks++;
            if (in1_ready !== (exp == 0) || in2_ready !== (exp == 1)) begin
                n_fail++;
                $display("FAIL alt_ready[%0d]: got r1=%b r2=%b want src %0d", i, in1_ready, in2_ready, exp);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== exp[0] ||
                out_data !== (exp == 1 ? 32'h20 + k2 : 32'h10 + k1)) begin
                n_fail++;
                $display("FAIL alt_out[%0d]: got v=%b s=%b d=%h want 1 %0d", i, out_valid, out_src, out_data, exp);
            end
            if (exp == 0) begin k1++; in1_data = 32'h10 + k1; end
            else          begin k2++; in2_data = 32'h20 + k2; end
        end
        in1_valid = 0; in2_valid = 0;
    endtask

    task automatic test_lock();
        logic [W-1:0] exp_d;
        logic         exp_s;
        do_reset();
        in1_valid = 1; in1_data = 32'h31; in1_last = 0;
        in2_valid = 1; in2_data = 32'h77; in2_last = 1;
        out_ready = 1;
        for (int j = 0; j < 4; j++) begin
            exp_s = (j == 3);
            exp_d = (j < 3) ? 32'h31 + j : 32'h77;
            #1;
            n_checks++;
            if (in1_ready !== !exp_s || in2_ready !== exp_s) begin
                n_fail++;
                $display("FAIL lock_ready[%0d]: got r1=%b r2=%b want src %b", j, in1_ready, in2_ready, exp_s);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== exp_s || out_data !== exp_d) begin
                n_fail++;
                $display("FAIL lock_out[%0d]: got v=%b s=%b d=%h want 1 %b %h", j, out_valid, out_src, out_data, exp_s, exp_d);
            end
            if (j == 0)      begin in1_data = 32'h32; end
            else if (j == 1) begin in1_data = 32'h33; in1_last = 1; end
            else if (j == 2) begin in1_valid = 0; end
            else             begin in2_valid = 0; end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in1_valid = 1; in1_data = 32'h11; in1_last = 1; out_ready = 1;
        @(posedge clk); #1;
        in1_data = 32'h22; out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (in1_ready !== 1'b0 || in2_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got r1=%b r2=%b want 0 0", i, in1_ready, in2_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h11) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1 11", i, out_valid, out_data);
            end
        end
        out_ready = 1;
        #1;
        n_checks++;
        if (in1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", in1_ready);
        end
        @(posedge clk); #1;
        in1_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h22) begin
            n_fail++;
            $display("FAIL bp_refill: got v=%b d=%h want 1 22", out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        in2_valid = 1; in2_data = 32'hB0; in2_last = 0; out_ready = 1;
        @(posedge clk); #1;
        in2_data = 32'hB1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: got v=%b busy=%b want 0 0", out_valid, busy);
        end
        in1_valid = 1; in1_data = 32'hC1; in1_last = 1;
        in2_data = 32'hC2; in2_last = 1;
        #1;
        n_checks++;
        if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_grant: got r1=%b r2=%b want 1 0", in1_ready, in2_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 32'hC1) begin
            n_fail++;
            $display("FAIL midrst_out: got v=%b s=%b d=%h want 1 0 c1", out_valid, out_src, out_data);
        end
        in1_valid = 0; in2_valid = 0;
    endtask

    // Randomized traffic: packet-level arbitration model + per-source scoreboard.
    task automatic test_random();
        logic [W:0] q1[$];
        logic [W:0] q2[$];
        logic [W:0] front;
        int  owner, prio, open_src;
        bit  open, mid1, mid2, acc1, acc2, drain, lastb, ld, e1, e2, done;
        int  nbeats;
        do_reset();
        owner = 0; prio = 1; open = 0; open_src = 0;
        mid1 = 0; mid2 = 0; nbeats = 0; done = 0;
        for (int c = 0; c < 10200; c++) begin
            drain = (c >= 10000);
            @(negedge clk);
            // Expected readies from packet ownership and round-robin priority.
            ld = !out_valid || out_ready;
            e1 = 0; e2 = 0;
            if (owner == 1)      e1 = ld;
            else if (owner == 2) e2 = ld;
            else if (in1_valid && in2_valid) begin e1 = ld && (prio == 1); e2 = ld && (prio == 2); end
            else begin e1 = ld && in1_valid; e2 = ld && in2_valid; end
            n_checks++;
            if (in1_ready !== e1 || in2_ready !== e2) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got r1=%b r2=%b want %b %b", c, in1_ready, in2_ready, e1, e2);
            end
            // Output beat against the queue of its source.
            if (out_valid && out_ready) begin
                nbeats++;
                n_checks++;
                if (out_src) begin
                    front = (q2.size() > 0) ? q2.pop_front() : {1'b1, {W{1'bx}}};
                end else begin
                    front = (q1.size() > 0) ? q1.pop_front() : {1'b1, {W{1'bx}}};
                end
                if ({out_last, out_data} !== front || (open && out_src != open_src[0])) begin
                    n_fail++;
                    $display("FAIL rand_beat[%0d]: got s=%b l=%b d=%h want l=%b d=%h open=%b/%0d",
                             c, out_src, out_last, out_data, front[W], front[W-1:0], open, open_src);
                end
                open = !out_last;
                open_src = out_src;
            end
            // Record input handshakes and advance the model.
            acc1 = in1_valid && in1_ready;
            acc2 = in2_valid && in2_ready;
            if (acc1) q1.push_back({in1_last, in1_data});
            if (acc2) q2.push_back({in2_last, in2_data});
            if (acc1 || acc2) begin
                lastb = acc1 ? in1_last : in2_last;
                if (lastb) begin owner = 0; prio = acc1 ? 2 : 1; end
                else owner = acc1 ? 1 : 2;
            end
            @(posedge clk); #1;
            if (acc1) begin mid1 = !in1_last; in1_valid = 0; end
            if (acc2) begin mid2 = !in2_last; in2_valid = 0; end
            if (!in1_valid && ((!drain && $urandom_range(3) != 0) || (drain && mid1))) begin
                in1_valid = 1; in1_data = $urandom; in1_last = drain || ($urandom_range(2) == 0);
            end
            if (!in2_valid && ((!drain && $urandom_range(3) != 0) || (drain && mid2))) begin
                in2_valid = 1; in2_data = $urandom; in2_last = drain || ($urandom_range(2) == 0);
            end
            out_ready = drain ? 1'b1 : ($urandom_range(9) < 7);
            if (drain && !in1_valid && !in2_valid && !mid1 && !mid2 && !out_valid &&
                q1.size() == 0 && q2.size() == 0) begin
                done = 1;
                break;
            end
        end
        n_checks++;
        if (!done || q1.size() != 0 || q2.size() != 0 || nbeats < 1000) begin
            n_fail++;
            $display("FAIL rand_drain: got done=%b q1=%0d q2=%0d beats=%0d want 1 0 0 >=1000",
                     done, q1.size(), q2.size(), nbeats);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_alternate();
        test_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
